dfd_cla_counter_bank: RTL
=========================

Name: dfd_cla_counter_bank

Overview:
- Parametrised multi-channel successor to the single CLA event counter: NUM_CTRS independent counters of CTR_WIDTH bits each, held internally (no CSR read-modify-write loop).
- Per channel: pulse/auto-increment control, target compare, reset-on-target, and a wrap or saturate mode.
- Sits between the CLA action decode (control pulses) and the CLA CSR block (config in, value/flags out); the CLA trigger logic consumes the flags.

Parameters:
- NUM_CTRS, 4, number of counter channels (1..16).
- CTR_WIDTH, 32, counter and target width in bits (8..48).

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ctr_clear  in  NUM_CTRS  per-channel clear pulse.
- ctr_inc_pulse  in  NUM_CTRS  per-channel single-increment pulse.
- ctr_auto_start  in  NUM_CTRS  enter auto-increment.
- ctr_auto_stop  in  NUM_CTRS  leave auto-increment.
- cfg_reset_on_target  in  NUM_CTRS  increment at target yields 0.
- cfg_saturate  in  NUM_CTRS  1 = hold at all-ones; 0 = wrap.
- cfg_target  in  NUM_CTRS*CTR_WIDTH  per-channel target, channel i at [i*W +: W].
- wr_en  in  NUM_CTRS  CSR load strobe per channel.
- wr_data  in  CTR_WIDTH  load value (shared).
- counter_value  out  NUM_CTRS*CTR_WIDTH  registered counters.
- auto_active  out  NUM_CTRS  1 while in INCREMENT state.
- target_match  out  NUM_CTRS  counter == target.
- target_overflow  out  NUM_CTRS  counter > target (unsigned).
- below_target  out  NUM_CTRS  counter < target.

Behaviour:
- Reset (async assert, sync release): all counters 0; state STOP; auto_active 0; target_match 0; target_overflow 0; below_target 0.
- Per-channel state machine:
  - STOP: ctr_auto_start -> INCREMENT, and the counter increments in that same cycle. ctr_auto_stop is ignored.
  - INCREMENT: increments every cycle. ctr_auto_stop -> STOP with no increment that cycle. ctr_auto_start and ctr_inc_pulse are ignored (at most +1 per cycle).
- Per-channel priority, highest first:
  1. wr_en: counter <= wr_data; state unchanged.
  2. ctr_clear: counter <= 0; state -> STOP.
  3. ctr_auto_stop (INCREMENT state only).
  4. Increment event: ctr_inc_pulse in STOP, ctr_auto_start in STOP, or every cycle in INCREMENT.
  5. Hold.
- Increment arithmetic, checked in this order:
  - cfg_reset_on_target=1 and current==target: next = 0.
  - current = all-ones and cfg_saturate=1: hold.
  - current = all-ones and cfg_saturate=0: wrap to 0.
  - Otherwise: current + 1, CTR_WIDTH-bit unsigned.
- Flags are registered from the next-cycle counter value, so they are coherent with counter_value in the same cycle (zero-lag view).
- The flag compare uses the cfg_target value present in the cycle the counter is updated. A target change with no counter change updates the flags one cycle later.
- Exactly one of the three flags is 1 after the first post-reset clock. During reset all three are 0.
- Channels are fully independent; simultaneous events on different channels never interact.
- Reset asserted mid-operation clears immediately (async); the first clock edge after release performs normal evaluation.

Optional Feature:
- Macro: DFD_CLA_CTR_SNAPSHOT_EN.
- Defined:
  - Adds input snapshot_req (1 bit) and output snapshot_value (NUM_CTRS*CTR_WIDTH).
  - On snapshot_req, all channels' next-cycle counter values are captured atomically into shadow registers, visible the following cycle.
  - Shadow registers reset to 0.
- Undefined: the ports and shadow registers do not exist.

Decomposition:
- dfd_cla_pkg gains:
  - enum cla_ctr_state_e {CTR_STOP, CTR_INCREMENT}.
  - struct cla_ctr_ctrl_s {clear, inc_pulse, auto_start, auto_stop}.
  - struct cla_ctr_flags_s {match, overflow, below}.
- One sub-module, dfd_cla_counter_chan (parameter CTR_WIDTH), instantiated NUM_CTRS times via generate. It holds the state machine, arithmetic and flags.
- The top level holds port slicing and the snapshot logic.

Test Plan:
- Reset release, then ctr_inc_pulse[0] x3 -> counter0 = 3; other counters stay 0; with target0=3: match0=1 in the cycle counter0 shows 3.
- W=8, target=255: ctr_auto_start[1] -> counter1 = 1,2,...,255 on consecutive cycles, auto_active1=1. cfg_saturate=1: stays 255. cfg_saturate=0: 255 -> 0 -> 1.
- target=5, cfg_reset_on_target=1, auto-increment -> sequence 4,5,0,1.
- ctr_clear and wr_en same cycle with wr_data=0x10 -> counter=0x10, state unchanged. ctr_clear with ctr_auto_stop in INCREMENT -> counter 0, STOP.
- In INCREMENT at 7: ctr_auto_stop with ctr_inc_pulse -> counter holds 7, auto_active=0. Reset_n pulsed mid-count -> counters and flags 0 immediately, no clock needed.
- With DFD_CLA_CTR_SNAPSHOT_EN: two channels auto-incrementing, snapshot_req at values 9 and 20 -> snapshot_value = 10, 21 next cycle and held while the counters advance.

Source files
------------

// File: rtl/dfd_cla_pkg.sv
// Shared types for the CLA counter bank: channel FSM states, per-channel control and flag bundles.
// Optional feature macro used by the bank: DFD_CLA_CTR_SNAPSHOT_EN.
package dfd_cla_pkg;

    localparam int CLA_MAX_CTRS      = 16;
    localparam int CLA_MIN_CTR_WIDTH = 8;
    localparam int CLA_MAX_CTR_WIDTH = 48;

    typedef enum logic {
        CTR_STOP      = 1'b0,
        CTR_INCREMENT = 1'b1
    } cla_ctr_state_e;

    typedef struct packed {
        logic clear;
        logic inc_pulse;
        logic auto_start;
        logic auto_stop;
    } cla_ctr_ctrl_s;

    typedef struct packed {
        logic match;
        logic overflow;
        logic below;
    } cla_ctr_flags_s;

    localparam cla_ctr_flags_s CLA_FLAGS_RESET = '{match: 1'b0, overflow: 1'b0, below: 1'b0};

    // Exactly one of the three compare flags must be set once out of reset.
    function automatic logic cla_flags_onehot(input cla_ctr_flags_s f);
        return (f.match ^ f.overflow ^ f.below) & ~(f.match & f.overflow & f.below);
    endfunction

endpackage

// File: rtl/dfd_cla_counter_chan.sv
// One CLA counter channel: STOP/INCREMENT state machine, increment arithmetic and target flags.
// With DFD_CLA_CTR_SNAPSHOT_EN the next-cycle counter value is exported for the bank's shadow capture.
module dfd_cla_counter_chan
    import dfd_cla_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  cla_ctr_ctrl_s        ctrl,
    input  logic                 cfg_reset_on_target,
    input  logic                 cfg_saturate,
    input  logic [CTR_WIDTH-1:0] cfg_target,
    input  logic                 wr_en,
    input  logic [CTR_WIDTH-1:0] wr_data,
    output logic [CTR_WIDTH-1:0] value,
    output logic                 auto_active,
    output cla_ctr_flags_s       flags
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    ,
    output logic [CTR_WIDTH-1:0] value_next
`endif
);

    localparam logic [CTR_WIDTH-1:0] ALL_ONES = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] ZERO     = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] ONE      = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    cla_ctr_state_e       state_r;
    cla_ctr_state_e       state_nxt_s;
    logic [CTR_WIDTH-1:0] value_r;
    logic [CTR_WIDTH-1:0] value_nxt_s;
    logic [CTR_WIDTH-1:0] inc_result_s;
    logic                 auto_active_r;
    cla_ctr_flags_s       flags_r;
    cla_ctr_flags_s       flags_nxt_s;

    // Reset-on-target wins over the all-ones saturate/wrap decision.
    function automatic logic [CTR_WIDTH-1:0] inc_value(
        input logic [CTR_WIDTH-1:0] cur,
        input logic [CTR_WIDTH-1:0] tgt,
        input logic                 rot,
        input logic                 sat
    );
        logic [CTR_WIDTH-1:0] res;
        if (rot && (cur == tgt)) begin
            res = ZERO;
        end else if (cur == ALL_ONES) begin
            res = sat ? ALL_ONES : ZERO;
        end else begin
            res = cur + ONE;
        end
        return res;
    endfunction

    assign inc_result_s = inc_value(value_r, cfg_target, cfg_reset_on_target, cfg_saturate);

    // Next state and next counter value, in event priority order
    always_comb begin
        state_nxt_s = state_r;
        value_nxt_s = value_r;
        if (wr_en) begin
            value_nxt_s = wr_data;
        end else if (ctrl.clear) begin
            value_nxt_s = ZERO;
            state_nxt_s = CTR_STOP;
        end else begin
            case (state_r)
                CTR_INCREMENT: begin
                    if (ctrl.auto_stop) begin
                        state_nxt_s = CTR_STOP;
                    end else begin
                        value_nxt_s = inc_result_s;
                    end
                end
                CTR_STOP: begin
                    if (ctrl.auto_start) begin
                        state_nxt_s = CTR_INCREMENT;
                        value_nxt_s = inc_result_s;
                    end else if (ctrl.inc_pulse) begin
                        value_nxt_s = inc_result_s;
                    end else begin
                        value_nxt_s = value_r;
                    end
                end
                default: begin
                    state_nxt_s = CTR_STOP;
                    value_nxt_s = value_r;
                end
            endcase
        end
    end

    // Flags are compared against the value being loaded so they line up with the counter output
    always_comb begin
        flags_nxt_s          = CLA_FLAGS_RESET;
        flags_nxt_s.match    = (value_nxt_s == cfg_target);
        flags_nxt_s.overflow = (value_nxt_s >  cfg_target);
        flags_nxt_s.below    = (value_nxt_s <  cfg_target);
    end

    // State, counter and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= CTR_STOP;
            value_r       <= ZERO;
            auto_active_r <= 1'b0;
            flags_r       <= CLA_FLAGS_RESET;
        end else begin
            state_r       <= state_nxt_s;
            value_r       <= value_nxt_s;
            auto_active_r <= (state_nxt_s == CTR_INCREMENT);
            flags_r       <= flags_nxt_s;
        end
    end

    assign value       = value_r;
    assign auto_active = auto_active_r;
    assign flags       = flags_r;

`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    assign value_next = value_nxt_s;
`endif

endmodule

// File: rtl/dfd_cla_counter_bank.sv
// Bank of NUM_CTRS independent CLA event counters with per-channel target flags.
// Optional DFD_CLA_CTR_SNAPSHOT_EN adds snapshot_req/snapshot_value atomic shadow capture.
module dfd_cla_counter_bank
    import dfd_cla_pkg::*;
#(
    parameter int NUM_CTRS  = 4,
    parameter int CTR_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CTRS-1:0]           ctr_clear,
    input  logic [NUM_CTRS-1:0]           ctr_inc_pulse,
    input  logic [NUM_CTRS-1:0]           ctr_auto_start,
    input  logic [NUM_CTRS-1:0]           ctr_auto_stop,
    input  logic [NUM_CTRS-1:0]           cfg_reset_on_target,
    input  logic [NUM_CTRS-1:0]           cfg_saturate,
    input  logic [NUM_CTRS*CTR_WIDTH-1:0] cfg_target,
    input  logic [NUM_CTRS-1:0]           wr_en,
    input  logic [CTR_WIDTH-1:0]          wr_data,
    output logic [NUM_CTRS*CTR_WIDTH-1:0] counter_value,
    output logic [NUM_CTRS-1:0]           auto_active,
    output logic [NUM_CTRS-1:0]           target_match,
    output logic [NUM_CTRS-1:0]           target_overflow,
    output logic [NUM_CTRS-1:0]           below_target
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    ,
    input  logic                          snapshot_req,
    output logic [NUM_CTRS*CTR_WIDTH-1:0] snapshot_value
`endif
);

`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    logic [NUM_CTRS*CTR_WIDTH-1:0] value_next_s;
    logic [NUM_CTRS*CTR_WIDTH-1:0] snapshot_r;
`endif

    genvar g;
    for (g = 0; g < NUM_CTRS; g = g + 1) begin : g_chan
        cla_ctr_ctrl_s  ctrl_s;
        cla_ctr_flags_s flags_s;

        assign ctrl_s.clear      = ctr_clear[g];
        assign ctrl_s.inc_pulse  = ctr_inc_pulse[g];
        assign ctrl_s.auto_start = ctr_auto_start[g];
        assign ctrl_s.auto_stop  = ctr_auto_stop[g];

        dfd_cla_counter_chan #(
            .CTR_WIDTH (CTR_WIDTH)
        ) u_chan (
            .clock               (clock),
            .reset_n             (reset_n),
            .ctrl                (ctrl_s),
            .cfg_reset_on_target (cfg_reset_on_target[g]),
            .cfg_saturate        (cfg_saturate[g]),
            .cfg_target          (cfg_target[g*CTR_WIDTH +: CTR_WIDTH]),
            .wr_en               (wr_en[g]),
            .wr_data             (wr_data),
            .value               (counter_value[g*CTR_WIDTH +: CTR_WIDTH]),
            .auto_active         (auto_active[g]),
            .flags               (flags_s)
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
            ,
            .value_next          (value_next_s[g*CTR_WIDTH +: CTR_WIDTH])
`endif
        );

        assign target_match[g]    = flags_s.match;
        assign target_overflow[g] = flags_s.overflow;
        assign below_target[g]    = flags_s.below;
    end

`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    // Shadow capture of every channel's next value in one edge, so the snapshot is coherent
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snapshot_r <= {(NUM_CTRS*CTR_WIDTH){1'b0}};
        end else if (snapshot_req) begin
            snapshot_r <= value_next_s;
        end else begin
            snapshot_r <= snapshot_r;
        end
    end

    assign snapshot_value = snapshot_r;
`endif

endmodule
